// File: rtl/regfile_sb.sv
// Multi-port integer register file with a per-register busy scoreboard for hazard detection.
// Optional feature macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_sb #(
  parameter int XLen    = 32,
  parameter int NReg    = 32,
  parameter int NRead   = 2,
  parameter int NWrite  = 1,
  parameter int ZeroReg = 1,
  localparam int AW     = $clog2(NReg)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NRead*AW-1:0]     ra_i,
  output logic [NRead*XLen-1:0]   rd_o,
  output logic [NRead-1:0]        rbusy_o,
  input  logic [NWrite*AW-1:0]    wa_i,
  input  logic [NWrite-1:0]       we_i,
  input  logic [NWrite*XLen-1:0]  wd_i,
  input  logic                    iss_valid_i,
  input  logic [AW-1:0]           iss_addr_i,
  output logic                    iss_ready_o,
  input  logic                    flush_i,
  output logic [NReg-1:0]         busy_o
);

  logic [XLen-1:0] mem_q [NReg];
  logic [XLen-1:0] mem_d [NReg];
  logic [NReg-1:0] busy_q;
  logic [NReg-1:0] busy_d;
  logic            iss_accept_s;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZeroReg != 0) && (a == {AW{1'b0}});
  endfunction

  assign iss_ready_o  = !busy_q[iss_addr_i] && !flush_i;
  assign iss_accept_s = iss_valid_i && iss_ready_o;
  assign busy_o       = busy_q;

  // Register write merge: later (higher-index) ports overwrite earlier ones.
  always_comb begin
    for (int r = 0; r < NReg; r++) begin
      mem_d[r] = mem_q[r];
      for (int k = 0; k < NWrite; k++) begin
        mem_d[r] = (we_i[k] && (wa_i[k*AW +: AW] == AW'(r)) && !is_zero_reg(AW'(r)))
                   ? wd_i[k*XLen +: XLen] : mem_d[r];
      end
    end
  end

  // Scoreboard update: writeback clears, accepted issue sets over clear, flush clears everything.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NReg; r++) begin
      for (int k = 0; k < NWrite; k++) begin
        busy_d[r] = (we_i[k] && (wa_i[k*AW +: AW] == AW'(r))) ? 1'b0 : busy_d[r];
      end
      busy_d[r] = (iss_accept_s && (iss_addr_i == AW'(r))) ? 1'b1 : busy_d[r];
      busy_d[r] = (flush_i || is_zero_reg(AW'(r))) ? 1'b0 : busy_d[r];
    end
  end

  // Combinational read ports with optional forwarding from the current write.
  always_comb begin
    rd_o    = {(NRead*XLen){1'b0}};
    rbusy_o = {NRead{1'b0}};
    for (int p = 0; p < NRead; p++) begin
      rd_o[p*XLen +: XLen] = mem_q[ra_i[p*AW +: AW]];
      rbusy_o[p]           = busy_q[ra_i[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWrite; k++) begin
        rd_o[p*XLen +: XLen] = (we_i[k] && (wa_i[k*AW +: AW] == ra_i[p*AW +: AW]))
                               ? wd_i[k*XLen +: XLen] : rd_o[p*XLen +: XLen];
        rbusy_o[p]           = (we_i[k] && (wa_i[k*AW +: AW] == ra_i[p*AW +: AW]))
                               ? 1'b0 : rbusy_o[p];
      end
`endif
      rd_o[p*XLen +: XLen] = is_zero_reg(ra_i[p*AW +: AW]) ? {XLen{1'b0}} : rd_o[p*XLen +: XLen];
      rbusy_o[p]           = is_zero_reg(ra_i[p*AW +: AW]) ? 1'b0 : rbusy_o[p];
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NReg; r++) begin
        mem_q[r] <= {XLen{1'b0}};
      end
      busy_q <= {NReg{1'b0}};
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (two read, two write ports): directed scenarios plus
// randomized traffic compared against an array-based reference model.
module tb_regfile_sb;
  localparam int XLen   = 32;
  localparam int NReg   = 32;
  localparam int NRead  = 2;
  localparam int NWrite = 2;
  localparam int AW     = 5;

  logic                   clk;
  logic                   rst_ni;
  logic [NRead*AW-1:0]    ra_i;
  logic [NRead*XLen-1:0]  rd_o;
  logic [NRead-1:0]       rbusy_o;
  logic [NWrite*AW-1:0]   wa_i;
  logic [NWrite-1:0]      we_i;
  logic [NWrite*XLen-1:0] wd_i;
  logic                   iss_valid_i;
  logic [AW-1:0]          iss_addr_i;
  logic                   iss_ready_o;
  logic                   flush_i;
  logic [NReg-1:0]        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLen-1:0] m_regs [NReg];
  bit              m_busy [NReg];

  regfile_sb #(.XLen(XLen), .NReg(NReg), .NRead(NRead), .NWrite(NWrite), .ZeroReg(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ra_i(ra_i), .rd_o(rd_o), .rbusy_o(rbusy_o),
    .wa_i(wa_i), .we_i(we_i), .wd_i(wd_i), .iss_valid_i(iss_valid_i),
    .iss_addr_i(iss_addr_i), .iss_ready_o(iss_ready_o), .flush_i(flush_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int r = 0; r < NReg; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic model_update();
    bit nb [NReg];
    bit acc;
    int a;
    acc = iss_valid_i && !m_busy[iss_addr_i] && !flush_i;
    nb  = m_busy;
    for (int k = 0; k < NWrite; k++) begin
      if (we_i[k]) begin
        a = int'(wa_i[k*AW +: AW]);
        nb[a] = 1'b0;
        if (a != 0) m_regs[a] = wd_i[k*XLen +: XLen];
      end
    end
    if (acc && iss_addr_i != 0) nb[iss_addr_i] = 1'b1;
    if (flush_i) for (int r = 0; r < NReg; r++) nb[r] = 1'b0;
    m_busy = nb;
  endtask

  function automatic logic [XLen-1:0] exp_rd(input int a);
    logic [XLen-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < NWrite; k++)
      if (we_i[k] && int'(wa_i[k*AW +: AW]) == a) v = wd_i[k*XLen +: XLen];
`endif
    return v;
  endfunction

  function automatic logic exp_rbusy(input int a);
    logic b;
    if (a == 0) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < NWrite; k++)
      if (we_i[k] && int'(wa_i[k*AW +: AW]) == a) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic [NReg-1:0] m_busy_vec();
    logic [NReg-1:0] v;
    for (int r = 0; r < NReg; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    we_i        = '0;
    iss_valid_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  task automatic set_ra(input int a0, input int a1);
    ra_i[0 +: AW]  = AW'(a0);
    ra_i[AW +: AW] = AW'(a1);
  endtask

  task automatic set_wr(input int k, input int a, input logic [XLen-1:0] d);
    we_i[k]              = 1'b1;
    wa_i[k*AW +: AW]     = AW'(a);
    wd_i[k*XLen +: XLen] = d;
  endtask

  task automatic issue(input int a);
    iss_valid_i = 1'b1;
    iss_addr_i  = AW'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_ni) model_update();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    model_reset();
    idle();
    wa_i = '0; wd_i = '0; ra_i = '0; iss_addr_i = '0;
    set_wr(0, 5, 32'h0000_DEAD);
    issue(5);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL reset_busy_during: got %h want 0", busy_o); end
    idle();
    set_ra(5, 5);
    rst_ni = 1'b1;
    #1;
    n_checks++;
    if (rd_o[0 +: XLen] !== 32'h0) begin n_fail++; $display("FAIL reset_rd5: got %h want 0", rd_o[0 +: XLen]); end
    n_checks++;
    if (rbusy_o !== 2'b00) begin n_fail++; $display("FAIL reset_rbusy: got %b want 00", rbusy_o); end
    n_checks++;
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy_o); end
    n_checks++;
    if (iss_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", iss_ready_o); end
    tick();
  endtask

  task automatic test_write_read();
    idle();
    set_wr(0, 3, 32'h1234_5678);
    tick();
    idle();
    set_ra(3, 3);
    #1;
    n_checks++;
    if (rd_o[0 +: XLen] !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_rd3_p0: got %h want 12345678", rd_o[0 +: XLen]); end
    n_checks++;
    if (rd_o[XLen +: XLen] !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_rd3_p1: got %h want 12345678", rd_o[XLen +: XLen]); end
    set_wr(1, 0, 32'hFFFF_FFFF);
    tick();
    idle();
    set_ra(0, 3);
    #1;
    n_checks++;
    if (rd_o[0 +: XLen] !== 32'h0) begin n_fail++; $display("FAIL wr_zero_reg: got %h want 0", rd_o[0 +: XLen]); end
  endtask

  task automatic test_scoreboard();
    idle();
    issue(7);
    #1;
    n_checks++;
    if (iss_ready_o !== 1'b1) begin n_fail++; $display("FAIL sb_ready_first: got %b want 1", iss_ready_o); end
    tick();
    idle();
    set_ra(7, 3);
    #1;
    n_checks++;
    if (busy_o[7] !== 1'b1) begin n_fail++; $display("FAIL sb_busy7_set: got %b want 1", busy_o[7]); end
    n_checks++;
    if (rbusy_o[0] !== 1'b1) begin n_fail++; $display("FAIL sb_rbusy7: got %b want 1", rbusy_o[0]); end
    issue(7);
    #1;
    n_checks++;
    if (iss_ready_o !== 1'b0) begin n_fail++; $display("FAIL sb_waw_stall: got %b want 0", iss_ready_o); end
    tick();
    set_wr(0, 7, 32'h7777_0007);
    tick();
    we_i = '0;
    #1;
    n_checks++;
    if (busy_o[7] !== 1'b0) begin n_fail++; $display("FAIL sb_busy7_clear: got %b want 0", busy_o[7]); end
    n_checks++;
    if (iss_ready_o !== 1'b1) begin n_fail++; $display("FAIL sb_ready_after_wb: got %b want 1", iss_ready_o); end
    tick();
    idle();
    #1;
    n_checks++;
    if (busy_o[7] !== 1'b1) begin n_fail++; $display("FAIL sb_reissue7: got %b want 1", busy_o[7]); end
    set_wr(0, 7, 32'h7777_0007);
    tick();
    idle();
  endtask

  task automatic test_issue_write_same_cycle();
    idle();
    issue(9);
    set_wr(0, 9, 32'h0909_CAFE);
    tick();
    idle();
    set_ra(9, 9);
    #1;
    n_checks++;
    if (busy_o[9] !== 1'b1) begin n_fail++; $display("FAIL same_cycle_busy9: got %b want 1", busy_o[9]); end
    n_checks++;
    if (rd_o[0 +: XLen] !== 32'h0909_CAFE) begin n_fail++; $display("FAIL same_cycle_rd9: got %h want 0909cafe", rd_o[0 +: XLen]); end
    set_wr(0, 9, 32'h0909_CAFE);
    tick();
    idle();
  endtask

  task automatic test_flush();
    idle();
    issue(4);
    tick();
    issue(7);
    tick();
    idle();
    #1;
    n_checks++;
    if (busy_o !== 32'h0000_0090) begin n_fail++; $display("FAIL flush_pre_busy: got %h want 00000090", busy_o); end
    flush_i = 1'b1;
    issue(12);
    set_wr(1, 20, 32'h2020_2020);
    #1;
    n_checks++;
    if (iss_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", iss_ready_o); end
    tick();
    idle();
    set_ra(20, 12);
    #1;
    n_checks++;
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL flush_busy: got %h want 0", busy_o); end
    n_checks++;
    if (rd_o[0 +: XLen] !== 32'h2020_2020) begin n_fail++; $display("FAIL flush_write_kept: got %h want 20202020", rd_o[0 +: XLen]); end
    n_checks++;
    if (rbusy_o[1] !== 1'b0) begin n_fail++; $display("FAIL flush_rbusy12: got %b want 0", rbusy_o[1]); end
  endtask

  task automatic test_dual_write();
    idle();
    set_wr(0, 10, 32'h0000_AAAA);
    set_wr(1, 10, 32'h0000_BBBB);
    set_ra(10, 10);
`ifdef REGFILE_BYPASS_EN
    #1;
    n_checks++;
    if (rd_o[0 +: XLen] !== 32'h0000_BBBB) begin n_fail++; $display("FAIL dual_bypass: got %h want 0000bbbb", rd_o[0 +: XLen]); end
`endif
    tick();
    idle();
    #1;
    n_checks++;
    if (rd_o[XLen +: XLen] !== 32'h0000_BBBB) begin n_fail++; $display("FAIL dual_same_addr: got %h want 0000bbbb", rd_o[XLen +: XLen]); end
    set_wr(0, 11, 32'h1111_1111);
    set_wr(1, 12, 32'h2222_2222);
    tick();
    idle();
    set_ra(11, 12);
    #1;
    n_checks++;
    if (rd_o[0 +: XLen] !== 32'h1111_1111) begin n_fail++; $display("FAIL dual_port0: got %h want 11111111", rd_o[0 +: XLen]); end
    n_checks++;
    if (rd_o[XLen +: XLen] !== 32'h2222_2222) begin n_fail++; $display("FAIL dual_port1: got %h want 22222222", rd_o[XLen +: XLen]); end
  endtask

  task automatic test_zero_issue();
    idle();
    issue(0);
    #1;
    n_checks++;
    if (iss_ready_o !== 1'b1) begin n_fail++; $display("FAIL zero_issue_ready: got %b want 1", iss_ready_o); end
    tick();
    idle();
    #1;
    n_checks++;
    if (busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL zero_issue_busy: got %b want 0", busy_o[0]); end
  endtask

  task automatic test_random(input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NWrite; k++) begin
        we_i[k] = ($urandom_range(0, 1) == 1);
        a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
        wa_i[k*AW +: AW]     = AW'(a);
        wd_i[k*XLen +: XLen] = $urandom;
      end
      iss_valid_i = ($urandom_range(0, 1) == 1);
      iss_addr_i  = AW'($urandom_range(0, 7));
      flush_i     = ($urandom_range(0, 15) == 0);
      set_ra($urandom_range(0, 7), $urandom_range(0, 31));
      #1;
      for (int p = 0; p < NRead; p++) begin
        a = int'(ra_i[p*AW +: AW]);
        n_checks++;
        if (rd_o[p*XLen +: XLen] !== exp_rd(a)) begin
          n_fail++; $display("FAIL rand_rd it=%0d p=%0d ra=%0d: got %h want %h", i, p, a, rd_o[p*XLen +: XLen], exp_rd(a));
        end
        n_checks++;
        if (rbusy_o[p] !== exp_rbusy(a)) begin
          n_fail++; $display("FAIL rand_rbusy it=%0d p=%0d ra=%0d: got %b want %b", i, p, a, rbusy_o[p], exp_rbusy(a));
        end
      end
      n_checks++;
      if (iss_ready_o !== (!m_busy[iss_addr_i] && !flush_i)) begin
        n_fail++; $display("FAIL rand_ready it=%0d: got %b want %b", i, iss_ready_o, (!m_busy[iss_addr_i] && !flush_i));
      end
      n_checks++;
      if (busy_o !== m_busy_vec()) begin
        n_fail++; $display("FAIL rand_busy it=%0d: got %h want %h", i, busy_o, m_busy_vec());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    issue(15);
    set_wr(0, 15, 32'h1515_1515);
    set_ra(3, 4);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL reset_mid_busy: got %h want 0", busy_o); end
    n_checks++;
    if (rd_o[0 +: XLen] !== 32'h0) begin n_fail++; $display("FAIL reset_mid_rd3: got %h want 0", rd_o[0 +: XLen]); end
    @(negedge clk);
    idle();
    rst_ni = 1'b1;
    set_ra(15, 3);
    #1;
    n_checks++;
    if (rd_o[0 +: XLen] !== 32'h0) begin n_fail++; $display("FAIL reset_mid_rd15: got %h want 0", rd_o[0 +: XLen]); end
    n_checks++;
    if (busy_o !== 32'h0) begin n_fail++; $display("FAIL reset_mid_busy_after: got %h want 0", busy_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_issue_write_same_cycle();
    test_flush();
    test_dual_write();
    test_zero_issue();
    test_random(400);
    test_reset_mid();
    test_random(100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
